// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit with architectural HI/LO registers.
// Divide support is compiled in only when MDU_DIV_EN is defined.
module mdu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [31:0] acc, q, m;
  logic        neg_q, skip, dbz;
  logic        accept, sgn, skip_in, dbz_in;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] prod, prod_fix;
`ifdef MDU_DIV_EN
  logic        is_div, neg_r;
  logic [32:0] div_sh, div_diff;
  logic [31:0] q_fix, r_fix;
`endif

  assign busy   = (state != IDLE);
  assign accept = (state == IDLE) && start && !flush;
  assign sgn    = !op[0];
  assign mag_a  = (sgn && A[31]) ? (32'd0 - A) : A;
  assign mag_b  = (sgn && B[31]) ? (32'd0 - B) : B;

`ifdef MDU_DIV_EN
  assign skip_in = op[1] && (B == 32'd0);
  assign dbz_in  = skip_in;
`else
  // Without divide hardware a divide op is accepted but produces no result.
  assign skip_in = op[1];
  assign dbz_in  = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = skip_in ? FIX : CALC;
      CALC:    if (cnt == 5'd31) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Shift-add step: {acc,q} shifts right, multiplier bits leave through q[0].
  assign mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : 33'd0);
  assign prod     = {acc, q};
  assign prod_fix = neg_q ? (64'd0 - prod) : prod;
`ifdef MDU_DIV_EN
  // Restoring step: remainder in acc, dividend bits leave through q[31].
  assign div_sh   = {acc, q[31]};
  assign div_diff = div_sh - {1'b0, m};
  assign q_fix    = neg_q ? (32'd0 - q) : q;
  assign r_fix    = neg_r ? (32'd0 - acc) : acc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0; acc <= '0; q <= '0; m <= '0;
      neg_q <= 1'b0; skip <= 1'b0; dbz <= 1'b0;
      done <= 1'b0; div_by_zero <= 1'b0;
      hi <= '0; lo <= '0;
`ifdef MDU_DIV_EN
      is_div <= 1'b0; neg_r <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
      if (accept) begin
        cnt   <= '0;
        acc   <= '0;
        q     <= mag_a;
        m     <= mag_b;
        neg_q <= sgn && (A[31] ^ B[31]);
        skip  <= skip_in;
        dbz   <= dbz_in;
`ifdef MDU_DIV_EN
        is_div <= op[1];
        neg_r  <= sgn && A[31];
`endif
      end
      if (state == CALC && !flush) begin
        cnt <= cnt + 5'd1;
`ifdef MDU_DIV_EN
        if (is_div) begin
          if (!div_diff[32]) begin
            acc <= div_diff[31:0];
            q   <= {q[30:0], 1'b1};
          end else begin
            acc <= div_sh[31:0];
            q   <= {q[30:0], 1'b0};
          end
        end else
`endif
        begin
          acc <= mul_sum[32:1];
          q   <= {mul_sum[0], q[31:1]};
        end
      end
      if (state == FIX && !flush) begin
        done        <= 1'b1;
        div_by_zero <= dbz;
        if (!skip) begin
`ifdef MDU_DIV_EN
          if (is_div) {hi, lo} <= {r_fix, q_fix};
          else        {hi, lo} <= prod_fix;
`else
          {hi, lo} <= prod_fix;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq: vector table plus hand-written
// sequences for flush, busy-time writes and mid-operation reset.
module tb_mdu_seq;
  logic        clk = 1'b0;
  logic        rst_n, start, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] A, B, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] mhi = '0, mlo = '0;

  mdu_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        keep;
    int          lat;
    logic        dbz;
    string       name;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [1:0] o, input logic [31:0] a, b, h, l,
                              input logic k, input int lat, input logic z, input string n);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.hi = h; v.lo = l;
    v.keep = k; v.lat = lat; v.dbz = z; v.name = n;
    return v;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    step();
    start = 1'b0; A = ~a; B = b + 32'd1;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 60) begin step(); n++; end
  endtask

  task automatic run(input vec_t v);
    int n;
    logic bad;
    logic [31:0] eh, el;
    bad = 1'b0;
    start_op(v.op, v.a, v.b);
    op = ~v.op;
    chk({v.name, "_done_T1"}, done, 0);
    n = 1;
    while (!done && n < 60) begin
      if (busy !== 1'b1 || div_by_zero !== 1'b0) bad = 1'b1;
      if (n == 5) begin start = 1'b1; op = 2'b01; A = 32'h5; B = 32'h7; end
      if (n == 6) start = 1'b0;
      step(); n++;
    end
    chk({v.name, "_busy"}, bad, 0);
    chk({v.name, "_lat"}, n, v.lat);
    chk({v.name, "_busy_at_done"}, busy, 0);
    chk({v.name, "_dbz"}, div_by_zero, v.dbz);
    eh = v.keep ? mhi : v.hi;
    el = v.keep ? mlo : v.lo;
    chk({v.name, "_hilo"}, {hi, lo}, {eh, el});
    mhi = eh; mlo = el;
  endtask

  initial begin
    int n;
    logic bad;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; A = '0; B = '0; wdata = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    step();

    vt.push_back(mk(2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 34, 0, "mult_m2x3"));
    vt.push_back(mk(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 34, 0, "multu_max"));
    vt.push_back(mk(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 34, 0, "mult_minsq"));
    vt.push_back(mk(2'b00, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 0, 34, 0, "mult_7xm1"));
    vt.push_back(mk(2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 0, 34, 0, "multu_shift"));
    vt.push_back(mk(2'b00, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 0, 34, 0, "mult_negneg"));
`ifdef MDU_DIV_EN
    vt.push_back(mk(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34, 0, "div_m7d2"));
    vt.push_back(mk(2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 0, 34, 0, "divu_100d7"));
    vt.push_back(mk(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 34, 0, "div_ovf"));
    vt.push_back(mk(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 34, 0, "div_7dm2"));
    vt.push_back(mk(2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 0, 34, 0, "divu_max"));
    vt.push_back(mk(2'b11, 32'h00000007, 32'h00000000, 32'h0, 32'h0, 1, 2, 1, "divu_by0"));
`else
    vt.push_back(mk(2'b11, 32'h00000007, 32'h00000003, 32'h0, 32'h0, 1, 2, 0, "divu_nodiv"));
    vt.push_back(mk(2'b10, 32'h00000007, 32'h00000000, 32'h0, 32'h0, 1, 2, 0, "div_nodiv_b0"));
`endif
    vt.push_back(mk(2'b01, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 0, 34, 0, "multu_3x5"));

    // Back-to-back: each vector starts in the done cycle of the previous one.
    foreach (vt[i]) run(vt[i]);

    // Flush at T+10, new start at T+11.
    start_op(2'b00, 32'h3, 32'h5);
    bad = 1'b0;
    for (int i = 1; i < 10; i++) begin if (done) bad = 1'b1; step(); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done | bad, 0);
    chk("flush_hilo", {hi, lo}, {mhi, mlo});
    run(mk(2'b00, 32'h2, 32'h3, 32'h0, 32'h6, 0, 34, 0, "after_flush"));

    // Flush coincident with FIX suppresses the result write.
    step();
    start_op(2'b01, 32'h10, 32'h10);
    for (int i = 1; i < 33; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flushfix_done", done, 0);
    chk("flushfix_hilo", {hi, lo}, {mhi, mlo});

    // lo write while busy is dropped, then applied once idle.
    start_op(2'b01, 32'h4, 32'h5);
    step(); step();
    lo_we = 1'b1; wdata = 32'h12345678;
    step();
    lo_we = 1'b0;
    chk("lowe_busy", lo, mlo);
    wait_done(n);
    chk("lowe_result", {hi, lo}, {32'h0, 32'd20});
    lo_we = 1'b1; wdata = 32'h12345678;
    step();
    lo_we = 1'b0;
    chk("lowe_idle", lo, 32'h12345678);
    hi_we = 1'b1; wdata = 32'hCAFEF00D;
    step();
    hi_we = 1'b0;
    chk("hiwe_idle", {hi, lo}, {32'hCAFEF00D, 32'h12345678});

    // Write coincident with accepted start lands first, result overwrites.
    hi_we = 1'b1; wdata = 32'hAAAA5555;
    start_op(2'b01, 32'h2, 32'h2);
    hi_we = 1'b0;
    chk("wr_start_hi", hi, 32'hAAAA5555);
    wait_done(n);
    chk("wr_start_result", {hi, lo}, {32'h0, 32'h4});

    // Reset at T+20 of a MULT; reset outranks start and writes.
    start_op(2'b00, 32'hFFFFFFFF, 32'h3);
    for (int i = 1; i < 20; i++) step();
    rst_n = 1'b0; start = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
    step();
    start = 1'b0; lo_we = 1'b0;
    chk("midrst_outs", {busy, done, div_by_zero}, 0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    mhi = '0; mlo = '0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin if (done || busy) bad = 1'b1; step(); end
    chk("midrst_nodone", bad, 0);
    run(mk(2'b00, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 34, 0, "post_rst"));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
